// File: rtl/hs32_mulseq.sv
// hs32_mulseq: 32x32 shift-add multiplier (low 32 bits) that borrows a shared ALU for each add.
// One iteration per granted cycle; optionally stops once the remaining multiplier bits are zero.
module hs32_mulseq #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [3:0]  i_fl,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_r,
  output logic [3:0]  o_fl,
  input  logic        i_flush,
  output logic        o_alu_req,
  input  logic        i_alu_gnt,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  output logic [3:0]  o_alu_op,
  input  logic [31:0] i_alu_r
);
  localparam logic [3:0] HS32A_ADD = 4'h0;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] acc, mcand, mplier;
  logic [3:0] fl_hold;
  logic [4:0] cnt;
  logic accept, step, last;
  assign accept = state == IDLE && i_valid && !i_flush;
  assign step = state == MUL && i_alu_gnt && !i_flush;
  // the current iteration is the final one when nothing is left above bit 0, or on the 32nd step
  assign last = EARLY_EXIT ? (mplier[31:1] == 31'd0) : (cnt == 5'd31);
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (i_flush) state_nx = IDLE;
    else
      case (state)
        IDLE: if (i_valid) state_nx = (EARLY_EXIT && i_b == 32'd0) ? DONE : MUL;
        MUL: if (i_alu_gnt && last) state_nx = DONE;
        DONE: if (i_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
  end
  always_comb begin
    o_ready = state == IDLE;
    o_valid = state == DONE;
    o_alu_req = state == MUL;
    o_r = state == DONE ? acc : 32'd0;
    o_fl = state == DONE ? {acc[31], acc == 32'd0, fl_hold[1:0]} : 4'd0;
    o_alu_a = acc;
    o_alu_b = mcand;
    o_alu_op = HS32A_ADD;
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      acc <= 32'd0;
      mcand <= 32'd0;
      mplier <= 32'd0;
      fl_hold <= 4'd0;
      cnt <= 5'd0;
    end else if (accept) begin
      acc <= 32'd0;
      mcand <= i_a;
      mplier <= i_b;
      fl_hold <= i_fl;
      cnt <= 5'd0;
    end else if (step) begin
      if (mplier[0]) acc <= i_alu_r;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 5'd1;
    end
endmodule

// File: tb/tb_hs32_mulseq.sv
// tb_hs32_mulseq: directed bench; u0 runs EARLY_EXIT=1 with handshaked results, u1 runs EARLY_EXIT=0 with i_ready tied high.
module tb_hs32_mulseq;
  logic clk = 0, rst_n = 0, valid = 0, ready = 0, flush = 0, stall = 0;
  logic [31:0] a = 0, b = 0;
  logic [3:0] fl = 0;
  int cyc = 0, t0 = 0, npass = 0, nchk = 0;
  logic gnt;
  logic rdy_o[2], vld[2], req[2];
  logic [31:0] r[2], alu_a[2], alu_b[2], alu_r[2];
  logic [3:0] ofl[2], op[2];
  assign gnt = !(stall && (cyc == t0 + 2 || cyc == t0 + 3));
  assign alu_r[0] = alu_a[0] + alu_b[0];
  assign alu_r[1] = alu_a[1] + alu_b[1];
  hs32_mulseq #(.EARLY_EXIT(1'b1)) u0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .o_ready(rdy_o[0]), .i_a(a), .i_b(b), .i_fl(fl),
    .o_valid(vld[0]), .i_ready(ready), .o_r(r[0]), .o_fl(ofl[0]), .i_flush(flush), .o_alu_req(req[0]),
    .i_alu_gnt(gnt), .o_alu_a(alu_a[0]), .o_alu_b(alu_b[0]), .o_alu_op(op[0]), .i_alu_r(alu_r[0]));
  hs32_mulseq #(.EARLY_EXIT(1'b0)) u1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .o_ready(rdy_o[1]), .i_a(a), .i_b(b), .i_fl(fl),
    .o_valid(vld[1]), .i_ready(1'b1), .o_r(r[1]), .o_fl(ofl[1]), .i_flush(flush), .o_alu_req(req[1]),
    .i_alu_gnt(gnt), .o_alu_a(alu_a[1]), .o_alu_b(alu_b[1]), .o_alu_op(op[1]), .i_alu_r(alu_r[1]));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", n, got, exp, cyc);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Model: phase 0 idle, 1 multiplying with rem granted iterations left, 2 holding result
  int ph[2], rem[2];
  logic [31:0] mr[2];
  logic [3:0] mf[2];
  always @(posedge clk or negedge rst_n)
    for (int k = 0; k < 2; k++) begin
      if (!rst_n || flush) ph[k] = 0;
      else if (ph[k] == 0) begin
        if (valid) begin
          logic [63:0] p;
          p = 64'(a) * 64'(b);
          mr[k] = p[31:0];
          mf[k] = {mr[k][31], mr[k] == 32'd0, fl[1:0]};
          rem[k] = 32;
          if (k == 0) begin
            rem[k] = 0;
            for (int i = 0; i < 32; i++) if (b[i]) rem[k] = i + 1;
          end
          ph[k] = rem[k] == 0 ? 2 : 1;
        end
      end else if (ph[k] == 1) begin
        if (gnt) begin
          rem[k]--;
          if (rem[k] == 0) ph[k] = 2;
        end
      end else if (k == 1 || ready) ph[k] = 0;
    end
  always @(negedge clk)
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d ready", k), 32'(rdy_o[k]), 32'(ph[k] == 0));
      chk($sformatf("u%0d valid", k), 32'(vld[k]), 32'(ph[k] == 2));
      chk($sformatf("u%0d alu_req", k), 32'(req[k]), 32'(ph[k] == 1));
      chk($sformatf("u%0d r", k), r[k], ph[k] == 2 ? mr[k] : 32'd0);
      chk($sformatf("u%0d fl", k), 32'(ofl[k]), ph[k] == 2 ? 32'(mf[k]) : 32'd0);
    end
  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rdy_o[0] && rdy_o[1]) return;
    end
    chk("idle timeout", 0, 1);
  endtask
  task automatic start(input logic [31:0] xa, input logic [31:0] xb, input logic [3:0] xf);
    wait_idle();
    a = xa; b = xb; fl = xf; valid = 1; t0 = cyc;
    tick();
    valid = 0; a = $urandom; b = $urandom; fl = 4'($urandom);
  endtask
  task automatic do_op(input logic [31:0] xa, input logic [31:0] xb, input logic [3:0] xf, input logic st,
                       input logic [31:0] er, input logic [3:0] ef, input int lat);
    bit s0 = 0, s1 = 0;
    int h = 0;
    stall = st;
    start(xa, xb, xf);
    for (int i = 0; i < 100 && !(s0 && s1 && !vld[0]); i++) begin
      @(negedge clk);
      ready = 0;
      if (vld[0]) begin
        if (!s0) begin
          s0 = 1;
          chk("u0 latency", 32'(cyc - t0), 32'(lat));
          chk("u0 product", r[0], er);
          chk("u0 flags", 32'(ofl[0]), 32'(ef));
        end
        h++;
        if (h == 3) ready = 1;
      end
      if (vld[1] && !s1) begin
        s1 = 1;
        chk("u1 latency", 32'(cyc - t0), 32'(33 + (st ? 2 : 0)));
        chk("u1 product", r[1], er);
      end
    end
    if (!(s0 && s1)) chk("result timeout", 0, 1);
    stall = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ready", 32'(rdy_o[0]), 1);
    chk("reset valid", 32'(vld[0]), 0);
    chk("reset r", r[0], 0);
    chk("reset fl", 32'(ofl[0]), 0);
    #2 rst_n = 1;
    do_op(6, 7, 4'b0011, 0, 42, 4'b0011, 4);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1100, 0, 32'h1, 4'b0000, 33);
    do_op(6, 7, 4'b1101, 1, 42, 4'b0001, 6);
    do_op(5, 0, 4'b0010, 0, 0, 4'b0110, 1);
    do_op(32'h4000_0000, 2, 4'b0001, 0, 32'h8000_0000, 4'b1001, 3);
    do_op(32'h0001_0000, 32'h0001_0000, 4'b0000, 0, 0, 4'b0100, 18);
    do_op(32'hFFFF_FFFF, 32'h8000_0000, 4'b0011, 0, 32'h8000_0000, 4'b1011, 33);
    start(3, 32'h8000_0000, 4'b1111);
    while (cyc < t0 + 5) tick();
    flush = 1;
    tick();
    flush = 0;
    @(negedge clk);
    chk("flush ready", 32'(rdy_o[0]), 1);
    chk("flush valid", 32'(vld[0]), 0);
    do_op(2, 3, 4'b0000, 0, 6, 4'b0000, 3);
    start(7, 32'h8000_0000, 4'b0011);
    while (cyc < t0 + 3) tick();
    #2 rst_n = 0;
    #1;
    chk("async rst alu_req", 32'(req[0]), 0);
    chk("async rst ready", 32'(rdy_o[0]), 1);
    chk("async rst valid", 32'(vld[0]), 0);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1;
    do_op(6, 7, 4'b0010, 0, 42, 4'b0010, 4);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/hs32_mulseq.md
HS32_MULSEQ -- requirements
Module: hs32_mulseq

Interface
REQ-001 SHALL have parameter EARLY_EXIT, default 1; 1 ends the multiply when the remaining multiplier bits are all zero, 0 always runs 32 iterations.
REQ-002 SHALL have port i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port i_valid  input  1  request valid.
REQ-005 SHALL have port o_ready  output  1  request accepted when i_valid and o_ready are both 1.
REQ-006 SHALL have port i_a  input  32  multiplicand.
REQ-007 SHALL have port i_b  input  32  multiplier.
REQ-008 SHALL have port i_fl  input  4  nzcv flags in, sampled at accept.
REQ-009 SHALL have port o_valid  output  1  result valid.
REQ-010 SHALL have port i_ready  input  1  result consumed when o_valid and i_ready are both 1.
REQ-011 SHALL have port o_r  output  32  product, low 32 bits.
REQ-012 SHALL have port o_fl  output  4  nzcv flags out.
REQ-013 SHALL have port i_flush  input  1  abort the operation and drop the result.
REQ-014 SHALL have port o_alu_req  output  1  request for the shared ALU.
REQ-015 SHALL have port i_alu_gnt  input  1  ALU granted to this block for the current cycle.
REQ-016 SHALL have port o_alu_a  output  32  ALU operand A, equal to the accumulator.
REQ-017 SHALL have port o_alu_b  output  32  ALU operand B, equal to the shifted multiplicand.
REQ-018 SHALL have port o_alu_op  output  4  ALU opcode; constant HS32A_ADD.
REQ-019 SHALL have port i_alu_r  input  32  combinational ALU result.

Function
REQ-020 SHALL implement the states IDLE, MUL and DONE; o_ready=1 only in IDLE; o_valid=1 only in DONE; o_alu_req=1 only in MUL.
REQ-021 SHALL, on accept in IDLE, load acc=0, mcand=i_a, mplier=i_b and fl_hold=i_fl.
REQ-022 SHALL, on accept with i_b==0 and EARLY_EXIT=1, go directly to DONE (acc=0); otherwise it SHALL go to MUL.
REQ-023 SHALL, in MUL, advance one iteration only in a cycle with i_alu_gnt=1, and SHALL leave all state unchanged in a cycle with i_alu_gnt=0.
REQ-024 SHALL, on each advancing iteration, do the following: if mplier[0]=1, set acc<=i_alu_r; set mcand<=mcand<<1 and mplier<=mplier>>1, discarding the bits shifted out.
REQ-025 SHALL leave MUL for DONE after the iteration where the next mplier==0 (EARLY_EXIT=1), or after exactly 32 advancing iterations (EARLY_EXIT=0).
REQ-026 SHALL give a latency, with zero stalls, of o_valid at accept cycle + N + 1, where N is the index of the highest set bit of i_b plus 1 (or 32 with EARLY_EXIT=0).
REQ-027 SHALL, in DONE, drive o_r=acc and hold it stable; o_fl = {acc[31], acc==0, fl_hold[1], fl_hold[0]}.
REQ-028 SHALL, in DONE, go to IDLE in the cycle after i_ready=1; no new request SHALL be accepted in the same cycle as that handshake.
REQ-029 SHALL, with i_flush=1 in any state, return to IDLE on the next edge with no o_valid pulse; i_flush SHALL take priority over accept, grant and i_ready.
REQ-030 SHALL ignore i_a, i_b and i_fl outside the accept cycle.
REQ-031 SHALL deassert o_alu_req in the same cycle the final iteration completes, i.e. combinationally from state.

Reset
REQ-032 SHALL, with i_reset_n=0, immediately force state=IDLE, acc=0, mcand=0, mplier=0 and fl_hold=0, independent of i_clk.
REQ-033 SHALL, during and after reset until the first accept, drive o_ready=1, o_valid=0, o_alu_req=0, o_r=0 and o_fl=0.
REQ-034 SHALL, on reset asserted mid-operation, drop the operation with no o_valid pulse.

Verification
REQ-035 SHALL cover: i_a=6, i_b=7, i_fl=4'b0011, gnt tied to 1, accept at T -> o_valid at T+4, o_r=42, o_fl=4'b0011.
REQ-036 SHALL cover: i_a=0xFFFFFFFF, i_b=0xFFFFFFFF, gnt=1 -> 32 iterations, o_valid at T+33, o_r=0x00000001, o_fl[3:2]=2'b00.
REQ-037 SHALL cover: i_a=6, i_b=7, gnt low in cycles T+2 and T+3 -> o_valid at T+6, o_r=42, o_alu_req=1 throughout T+1..T+5.
REQ-038 SHALL cover: i_a=5, i_b=0, EARLY_EXIT=1 -> o_valid at T+1, o_r=0, o_fl[2]=1, o_alu_req never 1.
REQ-039 SHALL cover: i_a=3, i_b=0x80000000 with i_flush=1 at T+5 -> IDLE at T+6, o_ready=1, o_valid never 1; a new request for 2*3 then yields 6.
REQ-040 SHALL cover: i_reset_n pulsed low at T+3 of a 32-iteration multiply, between clock edges -> o_alu_req=0 and o_ready=1 immediately, o_valid never 1.
